// File: rtl/vote_pkg.sv
// Shared constants and encodings for the ballot collector and its checker.
package vote_pkg;

    localparam int NP_N    = 32;
    localparam int VIP_N   = 8;
    localparam int TOTAL_N = NP_N + VIP_N + 1;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        CLS_NP   = 2'd0,
        CLS_VIP  = 2'd1,
        CLS_VVIP = 2'd2,
        CLS_RSV  = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/vote_ballot_check.sv
// Combinational ballot classifier: legality, duplicate detection and one-hot
// write enables for the addressed voter bit.
module vote_ballot_check
    import vote_pkg::*;
#(
    parameter int NP_N  = vote_pkg::NP_N,
    parameter int VIP_N = vote_pkg::VIP_N
) (
    input  logic [1:0]       cls,
    input  logic [4:0]       idx,
    input  logic [NP_N-1:0]  np_mask,
    input  logic [VIP_N-1:0] vip_mask,
    input  logic             vvip_mask,
    output logic             legal,
    output logic             dup,
    output logic [NP_N-1:0]  np_we,
    output logic [VIP_N-1:0] vip_we,
    output logic             vvip_we
);

    logic [NP_N-1:0]  np_hit;
    logic [VIP_N-1:0] vip_hit;
    logic             vvip_hit;

    // Reserved class and out-of-range indices produce no hit, hence illegal.
    always_comb begin
        np_hit   = '0;
        vip_hit  = '0;
        vvip_hit = (cls == CLS_VVIP) && (idx == 5'd0);
        for (int i = 0; i < NP_N; i++)
            np_hit[i] = (cls == CLS_NP) && (idx == 5'(i));
        for (int i = 0; i < VIP_N; i++)
            vip_hit[i] = (cls == CLS_VIP) && (idx == 5'(i));
    end

    assign legal   = (|np_hit) | (|vip_hit) | vvip_hit;
    assign dup     = (|(np_hit & np_mask)) | (|(vip_hit & vip_mask)) | (vvip_hit & vvip_mask);
    assign np_we   = dup ? '0 : np_hit;
    assign vip_we  = dup ? '0 : vip_hit;
    assign vvip_we = vvip_hit & ~dup;

endmodule

// File: rtl/vote_ballot_collector.sv
// Session FSM collecting individual ballots into the packed np/vip/vvip vectors.
// VOTE_AUTOCLOSE_EN: close the session automatically once every voter has cast.
module vote_ballot_collector
    import vote_pkg::*;
#(
    parameter int NP_N  = vote_pkg::NP_N,
    parameter int VIP_N = vote_pkg::VIP_N,
    parameter int CNT_W = vote_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             close,
    input  logic             bal_valid,
    output logic             bal_ready,
    input  logic [1:0]       bal_class,
    input  logic [4:0]       bal_idx,
    input  logic             bal_choice,
    output logic [NP_N-1:0]  np,
    output logic [VIP_N-1:0] vip,
    output logic             vvip,
    output logic [CNT_W-1:0] cast_cnt,
    output logic             bal_err,
    output logic             out_valid,
    input  logic             out_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NP_N + VIP_N + 1);

    state_e           state_q, state_n;
    logic [NP_N-1:0]  np_mask, np_we;
    logic [VIP_N-1:0] vip_mask, vip_we;
    logic             vvip_mask, vvip_we;
    logic             legal, dup, accept, wr;

    vote_ballot_check #(.NP_N(NP_N), .VIP_N(VIP_N)) u_check (
        .cls      (bal_class),
        .idx      (bal_idx),
        .np_mask  (np_mask),
        .vip_mask (vip_mask),
        .vvip_mask(vvip_mask),
        .legal    (legal),
        .dup      (dup),
        .np_we    (np_we),
        .vip_we   (vip_we),
        .vvip_we  (vvip_we)
    );

    assign accept = bal_valid & bal_ready;
    assign wr     = accept & legal & ~dup;

    always_comb begin
        state_n   = state_q;
        bal_ready = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_n = S_OPEN;
            S_OPEN: begin
`ifdef VOTE_AUTOCLOSE_EN
                // Full electorate: stop accepting and seal on the next edge.
                if (cast_cnt == CNT_MAX) begin
                    state_n = S_HOLD;
                end else begin
                    bal_ready = 1'b1;
                    if (close) state_n = S_HOLD;
                end
`else
                bal_ready = 1'b1;
                if (close) state_n = S_HOLD;
`endif
            end
            S_HOLD: if (out_ack) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            np        <= '0;
            vip       <= '0;
            vvip      <= 1'b0;
            np_mask   <= '0;
            vip_mask  <= '0;
            vvip_mask <= 1'b0;
            cast_cnt  <= '0;
            bal_err   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            bal_err   <= accept & ~wr;
            out_valid <= (state_n == S_HOLD);
            if (state_q == S_IDLE && start) begin
                np        <= '0;
                vip       <= '0;
                vvip      <= 1'b0;
                np_mask   <= '0;
                vip_mask  <= '0;
                vvip_mask <= 1'b0;
                cast_cnt  <= '0;
            end else if (wr) begin
                np        <= (np & ~np_we) | (np_we & {NP_N{bal_choice}});
                vip       <= (vip & ~vip_we) | (vip_we & {VIP_N{bal_choice}});
                if (vvip_we) vvip <= bal_choice;
                np_mask   <= np_mask | np_we;
                vip_mask  <= vip_mask | vip_we;
                vvip_mask <= vvip_mask | vvip_we;
                if (cast_cnt != CNT_MAX) cast_cnt <= cast_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed self-checking bench for vote_ballot_collector.
module tb_vote_ballot_collector;

    logic        clk = 1'b0;
    logic        rst_n, start, close, bal_valid, bal_choice, out_ack;
    logic [1:0]  bal_class;
    logic [4:0]  bal_idx;
    logic        bal_ready, vvip, bal_err, out_valid;
    logic [31:0] np;
    logic [7:0]  vip;
    logic [5:0]  cast_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vote_ballot_collector dut (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close),
        .bal_valid(bal_valid), .bal_ready(bal_ready), .bal_class(bal_class),
        .bal_idx(bal_idx), .bal_choice(bal_choice), .np(np), .vip(vip),
        .vvip(vvip), .cast_cnt(cast_cnt), .bal_err(bal_err),
        .out_valid(out_valid), .out_ack(out_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [4:0] i, input logic ch);
        bal_valid = 1'b1; bal_class = c; bal_idx = i; bal_choice = ch;
        tick();
        bal_valid = 1'b0;
    endtask

    task automatic open_session();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic end_session();
        close = 1'b1; tick(); close = 1'b0;
        out_ack = 1'b1; tick(); out_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (np !== 32'h0 || vip !== 8'h0 || vvip !== 1'b0) begin
            errors++; $display("FAIL reset_vec np=%h vip=%h vvip=%b exp 0", np, vip, vvip); end
        checks++; if (cast_cnt !== 6'd0 || bal_err !== 1'b0 || out_valid !== 1'b0 || bal_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ctl cnt=%0d err=%b ov=%b rdy=%b exp 0", cast_cnt, bal_err, out_valid, bal_ready); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bal_ready !== 1'b0) begin
            errors++; $display("FAIL idle_ready act=%b exp 0", bal_ready); end
    endtask

    task automatic test_basic();
        logic errseen = 1'b0;
        open_session();
        checks++; if (bal_ready !== 1'b1 || cast_cnt !== 6'd0) begin
            errors++; $display("FAIL open_state rdy=%b cnt=%0d exp 1/0", bal_ready, cast_cnt); end
        send(2'd0, 5'd3, 1'b1); errseen |= bal_err;
        send(2'd0, 5'd7, 1'b1); errseen |= bal_err;
        send(2'd1, 5'd2, 1'b1); errseen |= bal_err;
        send(2'd2, 5'd0, 1'b1); errseen |= bal_err;
        close = 1'b1; tick(); close = 1'b0; errseen |= bal_err;
        checks++; if (out_valid !== 1'b1 || bal_ready !== 1'b0) begin
            errors++; $display("FAIL basic_hold ov=%b rdy=%b exp 1/0", out_valid, bal_ready); end
        checks++; if (np !== 32'h00000088 || vip !== 8'h04 || vvip !== 1'b1) begin
            errors++; $display("FAIL basic_vec np=%h vip=%h vvip=%b exp 00000088/04/1", np, vip, vvip); end
        checks++; if (cast_cnt !== 6'd4 || errseen !== 1'b0) begin
            errors++; $display("FAIL basic_cnt cnt=%0d err=%b exp 4/0", cast_cnt, errseen); end
        out_ack = 1'b1; tick(); out_ack = 1'b0;
        checks++; if (out_valid !== 1'b0 || bal_ready !== 1'b0 || np !== 32'h00000088) begin
            errors++; $display("FAIL basic_idle ov=%b rdy=%b np=%h exp 0/0/00000088", out_valid, bal_ready, np); end
    endtask

    task automatic test_dup_illegal();
        open_session();
        checks++; if (np !== 32'h0 || cast_cnt !== 6'd0) begin
            errors++; $display("FAIL start_clear np=%h cnt=%0d exp 0/0", np, cast_cnt); end
        send(2'd0, 5'd5, 1'b1);
        checks++; if (bal_err !== 1'b0 || np !== 32'h20) begin
            errors++; $display("FAIL first_vote err=%b np=%h exp 0/00000020", bal_err, np); end
        send(2'd0, 5'd5, 1'b0);
        checks++; if (bal_err !== 1'b1 || np !== 32'h20) begin
            errors++; $display("FAIL dup err=%b np=%h exp 1/00000020", bal_err, np); end
        send(2'd1, 5'd9, 1'b1);
        checks++; if (bal_err !== 1'b1 || vip !== 8'h00) begin
            errors++; $display("FAIL vip_range err=%b vip=%h exp 1/00", bal_err, vip); end
        send(2'd3, 5'd0, 1'b1);
        checks++; if (bal_err !== 1'b1) begin
            errors++; $display("FAIL class3 err=%b exp 1", bal_err); end
        send(2'd2, 5'd1, 1'b1);
        checks++; if (bal_err !== 1'b1 || vvip !== 1'b0) begin
            errors++; $display("FAIL vvip_idx err=%b vvip=%b exp 1/0", bal_err, vvip); end
        tick();
        checks++; if (bal_err !== 1'b0 || cast_cnt !== 6'd1) begin
            errors++; $display("FAIL err_pulse err=%b cnt=%0d exp 0/1", bal_err, cast_cnt); end
        end_session();
    endtask

    task automatic test_close_simul_and_hold();
        open_session();
        close = 1'b1; bal_valid = 1'b1; bal_class = 2'd1; bal_idx = 5'd0; bal_choice = 1'b1;
        tick();
        close = 1'b0; bal_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || vip !== 8'h01 || cast_cnt !== 6'd1) begin
            errors++; $display("FAIL close_simul ov=%b vip=%h cnt=%0d exp 1/01/1", out_valid, vip, cast_cnt); end
        bal_valid = 1'b1; bal_class = 2'd0; bal_idx = 5'd0; bal_choice = 1'b1; start = 1'b1; close = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || bal_ready !== 1'b0 || np !== 32'h0 || vip !== 8'h01 || cast_cnt !== 6'd1) begin
                errors++; $display("FAIL hold_stable cyc=%0d ov=%b rdy=%b np=%h vip=%h cnt=%0d exp 1/0/0/01/1",
                                   k, out_valid, bal_ready, np, vip, cast_cnt); end
        end
        bal_valid = 1'b0; start = 1'b0; close = 1'b0;
        out_ack = 1'b1; tick(); out_ack = 1'b0;
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_exit ov=%b exp 0", out_valid); end
        // out_ack already high when HOLD is entered
        open_session();
        close = 1'b1; out_ack = 1'b1; tick(); close = 1'b0;
        checks++; if (out_valid !== 1'b1) begin
            errors++; $display("FAIL early_ack_hold ov=%b exp 1", out_valid); end
        tick(); out_ack = 1'b0;
        checks++; if (out_valid !== 1'b0 || bal_ready !== 1'b0) begin
            errors++; $display("FAIL early_ack_idle ov=%b rdy=%b exp 0/0", out_valid, bal_ready); end
    endtask

    task automatic test_async_reset();
        open_session();
        send(2'd0, 5'd1, 1'b1);
        send(2'd1, 5'd3, 1'b1);
        send(2'd2, 5'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (np !== 32'h0 || vip !== 8'h0 || vvip !== 1'b0 || cast_cnt !== 6'd0 || bal_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst np=%h vip=%h vvip=%b cnt=%0d rdy=%b ov=%b exp all 0",
                               np, vip, vvip, cast_cnt, bal_ready, out_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        open_session();
        send(2'd0, 5'd1, 1'b0);
        checks++; if (bal_err !== 1'b0 || cast_cnt !== 6'd1 || np !== 32'h0) begin
            errors++; $display("FAIL post_rst err=%b cnt=%0d np=%h exp 0/1/0", bal_err, cast_cnt, np); end
        end_session();
    endtask

    task automatic test_full();
        open_session();
        for (int i = 0; i < 32; i++) send(2'd0, 5'(i), 1'b1);
        for (int i = 0; i < 8; i++) send(2'd1, 5'(i), 1'b1);
        send(2'd2, 5'd0, 1'b1);
        checks++; if (cast_cnt !== 6'd41 || np !== 32'hFFFFFFFF || vip !== 8'hFF || vvip !== 1'b1) begin
            errors++; $display("FAIL full_vec cnt=%0d np=%h vip=%h vvip=%b exp 41/FFFFFFFF/FF/1", cast_cnt, np, vip, vvip); end
`ifdef VOTE_AUTOCLOSE_EN
        checks++; if (bal_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL auto_gap rdy=%b ov=%b exp 0/0", bal_ready, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || cast_cnt !== 6'd41) begin
            errors++; $display("FAIL auto_close ov=%b cnt=%0d exp 1/41", out_valid, cast_cnt); end
        out_ack = 1'b1; tick(); out_ack = 1'b0;
`else
        checks++; if (bal_ready !== 1'b1) begin
            errors++; $display("FAIL full_ready rdy=%b exp 1", bal_ready); end
        send(2'd0, 5'd0, 1'b0);
        checks++; if (bal_err !== 1'b1 || out_valid !== 1'b0 || cast_cnt !== 6'd41 || np !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL extra_ballot err=%b ov=%b cnt=%0d np=%h exp 1/0/41/FFFFFFFF",
                               bal_err, out_valid, cast_cnt, np); end
        end_session();
`endif
    endtask

    initial begin
        start = 1'b0; close = 1'b0; bal_valid = 1'b0; bal_class = 2'd0;
        bal_idx = 5'd0; bal_choice = 1'b0; out_ack = 1'b0; rst_n = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_dup_illegal();
        test_close_simul_and_hold();
        test_async_reset();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
